mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

Sequences MEM-stage data-memory accesses for the five-stage pipeline. Accepts one load or store from the MEM stage, runs a req/ack handshake with the data memory, and stalls the pipeline while the access is outstanding. Aligns store data and generates byte enables. Extracts and sign/zero-extends load data using the 3-bit load-type code produced by the load decoder. Flags misaligned addresses and bus timeouts.

## Interface
- TIMEOUT, 16, max cycles in ACCESS without dm_ack before bus error (≥2).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  MEM-stage op present.
- mem_is_load  in  1  op is a load.
- mem_is_store  in  1  op is a store.
- mem_ld_type  in  3  load-type code: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu.
- mem_st_size  in  2  00 byte, 01 half, 10 word.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, LSB-justified.
- dm_req  out  1  memory request.
- dm_we  out  1  1 = write.
- dm_addr  out  32  word address, bits [1:0] = 0.
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-aligned store data.
- dm_ack  in  1  request accepted/completed.
- dm_rdata  in  32  read word, valid with dm_ack.
- stall  out  1  freeze IF–MEM stages.
- wb_valid  out  1  one-cycle pulse, load data ready.
- wb_rdata  out  32  extended load result.
- misalign  out  1  one-cycle pulse, misaligned op dropped.
- bus_err  out  1  one-cycle pulse, timeout.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: when mem_valid & (mem_is_load | mem_is_store):
  - Misaligned (word addr[1:0]≠0; half addr[0]≠0): pulse misalign next cycle, stay IDLE, no bus activity.
  - Otherwise latch op, addr, data, type; go to ACCESS.
- Load takes priority if both mem_is_load and mem_is_store are set.
- Load-type codes 101–111 behave as lw.
- ACCESS:
  - dm_req = 1; dm_we, dm_addr, dm_be and dm_wdata are held stable from the latched op until acked.
  - On dm_ack: for loads, capture the extended dm_rdata into wb_rdata; go to RESP.
  - Timeout counter increments each ACCESS cycle without ack. On reaching TIMEOUT: pulse bus_err, drop dm_req, go to IDLE, no wb_valid.
- RESP: wb_valid = 1 for loads only (stores produce no pulse); go to IDLE.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 0011 if addr[1] = 0, else 1100.
  - word: 1111.
- Store data: byte replicated ×4, half replicated ×2, word unchanged.
- Load extract:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend.
- dm_ack outside ACCESS is ignored.

## Timing
- Reset values: dm_req, dm_we, stall, wb_valid, misalign and bus_err are 0; dm_addr, dm_be, dm_wdata and wb_rdata are 0; state = IDLE; counter = 0.
- stall is combinational:
  - 1 in IDLE when a valid aligned op is presented;
  - 1 throughout ACCESS;
  - 0 in RESP.
- Cycle 0: op presented, stall = 1.
- Cycle 1: dm_req = 1; earliest dm_ack.
- Cycle 2 (zero-wait ack): RESP, wb_valid = 1, stall = 0. Each ack wait cycle adds one cycle.
- Back-to-back ops: a new op may be presented in the RESP cycle's successor (IDLE) with no bubble.
- Misaligned op: stall stays 0; misalign pulses in cycle 1.
- Reset mid-ACCESS: dm_req = 0 at the next edge, no wb_valid, counter cleared, latched op discarded.
- wb_rdata holds its value until the next load completes.

## Structure
- Shared package mem_pkg holds:
  - load-type code constants (shared with the load decoder);
  - store-size constants;
  - FSM state encoding.
- Sub-module load_data_align (combinational):
  - inputs: dm_rdata, addr[1:0], load type;
  - output: extended 32-bit result.
- FSM, counter, store alignment and the handshake stay in the top module.

## Test plan
- lw at 0x100; dm_rdata = 0xDEADBEEF, ack in cycle 1 → dm_addr = 0x100, dm_be = 1111, wb_valid in cycle 2, wb_rdata = 0xDEADBEEF, stall high cycles 0–1.
- lb at 0x103, rdata = 0x80112233 → wb_rdata = 0xFFFFFF80. lbu at the same address → 0x00000080. lhu at 0x102 → 0x00008011.
- sh at 0x102, wdata = 0x0000ABCD, ack delayed 3 cycles → dm_be = 1100, dm_wdata = 0xABCDABCD, dm_we = 1, signals stable for 4 cycles, no wb_valid.
- lw at 0x101 → misalign pulse in cycle 1; dm_req never asserted; stall = 0.
- Load with no ack, TIMEOUT = 16 → bus_err pulses after 16 ACCESS cycles, dm_req drops, FSM returns to IDLE.
- rst asserted in the 2nd ACCESS cycle → all outputs 0 at the next edge. A subsequent lw completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared load-type/store-size codes and sequencer state encoding
package mem_pkg;
  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  function automatic logic [1:0] ld_size(input logic [2:0] t);
    return (t == LD_LB || t == LD_LBU) ? SZ_B : (t == LD_LH || t == LD_LHU) ? SZ_H : SZ_W;
  endfunction
endpackage

// File: rtl/load_data_align.sv
// load_data_align: selects the addressed byte/half of a read word and sign/zero-extends it
module load_data_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    result = ld_type == LD_LB  ? {{24{b[7]}}, b} :
             ld_type == LD_LBU ? {24'b0, b} :
             ld_type == LD_LH  ? {{16{h[15]}}, h} :
             ld_type == LD_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: MEM-stage load/store sequencing over a req/ack data-memory bus
module mem_access_sequencer
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_is_load,
  input  logic        mem_is_store,
  input  logic [2:0]  mem_ld_type,
  input  logic [1:0]  mem_st_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_rdata,
  output logic        misalign,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic op_load, op_store;
  logic [1:0] op_lane;
  logic [2:0] op_type;
  logic take, aligned, start, expire;
  logic [1:0] size;
  logic [3:0] be_n;
  logic [31:0] wdata_n, ld_result;
  load_data_align u_align (
    .rdata  (dm_rdata),
    .lane   (op_lane),
    .ld_type(op_type),
    .result (ld_result)
  );
  always_comb begin
    take = mem_valid & (mem_is_load | mem_is_store);
    size = mem_is_load ? ld_size(mem_ld_type) : mem_st_size;
    aligned = size == SZ_B ? 1'b1 : size == SZ_H ? !mem_addr[0] : mem_addr[1:0] == 2'b00;
    start = state == S_IDLE & take & aligned;
    expire = state == S_ACCESS & !dm_ack & cnt == CW'(TIMEOUT - 1);
    be_n = size == SZ_B ? 4'b0001 << mem_addr[1:0] : size == SZ_H ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n = mem_st_size == SZ_B ? {4{mem_wdata[7:0]}} : mem_st_size == SZ_H ? {2{mem_wdata[15:0]}} : mem_wdata;
    state_n = state == S_IDLE ? (start ? S_ACCESS : S_IDLE) :
              state == S_ACCESS ? (dm_ack ? S_RESP : expire ? S_IDLE : S_ACCESS) : S_IDLE;
    dm_req = state == S_ACCESS;
    dm_we = dm_req & op_store;
    stall = start | state == S_ACCESS;
    wb_valid = state == S_RESP & op_load;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      op_load <= 1'b0;
      op_store <= 1'b0;
      op_lane <= 2'b00;
      op_type <= LD_LW;
      dm_addr <= '0;
      dm_be <= '0;
      dm_wdata <= '0;
      wb_rdata <= '0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      misalign <= state == S_IDLE & take & !aligned;
      bus_err <= expire;
      if (start) begin
        cnt <= '0;
        op_load <= mem_is_load;
        op_store <= !mem_is_load;
        op_lane <= mem_addr[1:0];
        op_type <= mem_ld_type;
        dm_addr <= {mem_addr[31:2], 2'b00};
        dm_be <= be_n;
        dm_wdata <= wdata_n;
      end
      if (state == S_ACCESS) cnt <= cnt + 1'b1;
      if (state == S_ACCESS & dm_ack & op_load) wb_rdata <= ld_result;
    end
  end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: vector table, corner sequences and randomized ops against a reference model
module tb_mem_access_sequencer;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_valid = 0, mem_is_load = 0, mem_is_store = 0;
  logic [2:0] mem_ld_type = 0;
  logic [1:0] mem_st_size = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, dm_rdata = 0;
  logic dm_ack = 0;
  logic dm_req, dm_we, stall, wb_valid, misalign, bus_err;
  logic [31:0] dm_addr, dm_wdata, wb_rdata;
  logic [3:0] dm_be;
  int checks = 0, failures = 0;
  logic [31:0] prev_rd = 0;
  typedef struct {
    logic ld, st;
    logic [2:0] lt;
    logic [1:0] ss;
    logic [31:0] addr, wdata, rdata;
    int dly;
    logic al;
    logic [3:0] be;
    logic [31:0] wd, res;
  } vec_t;
  mem_access_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_is_load(mem_is_load),
    .mem_is_store(mem_is_store), .mem_ld_type(mem_ld_type), .mem_st_size(mem_st_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .stall(stall), .wb_valid(wb_valid), .wb_rdata(wb_rdata),
    .misalign(misalign), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  function automatic vec_t model(input logic ld, input logic st, input logic [2:0] lt, input logic [1:0] ss,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata, input int dly);
    vec_t r;
    int sz, lane;
    logic [31:0] v;
    r.ld = ld; r.st = st; r.lt = lt; r.ss = ss; r.addr = addr; r.wdata = wdata; r.rdata = rdata; r.dly = dly;
    sz = ld ? ((lt == 1 || lt == 3) ? 1 : (lt == 2 || lt == 4) ? 2 : 4) : (ss == 0 ? 1 : ss == 1 ? 2 : 4);
    lane = int'(addr % 4);
    r.al = (addr % sz) == 0;
    r.be = 4'(((1 << sz) - 1) << lane);
    r.wd = sz == 1 ? wdata[7:0] * 32'h01010101 : sz == 2 ? wdata[15:0] * 32'h00010001 : wdata;
    v = rdata >> (8 * lane);
    v = sz == 1 ? v & 32'hFF : sz == 2 ? v & 32'hFFFF : v;
    if (lt == 1 && v >= 32'h80) v = v - 32'h100;
    if (lt == 2 && v >= 32'h8000) v = v - 32'h10000;
    r.res = v;
    return r;
  endfunction
  task automatic op(input vec_t v);
    @(posedge clk); #1;
    mem_valid = 1; mem_is_load = v.ld; mem_is_store = v.st; mem_ld_type = v.lt; mem_st_size = v.ss;
    mem_addr = v.addr; mem_wdata = v.wdata; dm_ack = 1'($urandom); dm_rdata = $urandom;
    @(negedge clk);
    chk("stall_c0", stall, v.al);
    chk("req_c0", dm_req, 0);
    chk("wbv_c0", wb_valid, 0);
    chk("mis_c0", misalign, 0);
    chk("rdata_hold", wb_rdata, prev_rd);
    @(posedge clk); #1;
    mem_valid = 0; dm_ack = 0;
    if (!v.al) begin
      @(negedge clk);
      chk("misalign", misalign, 1);
      chk("mis_req", dm_req, 0);
      chk("mis_stall", stall, 0);
      return;
    end
    for (int c = 0; c < TO; c++) begin
      dm_ack = (c == v.dly);
      dm_rdata = (c == v.dly) ? v.rdata : $urandom;
      @(negedge clk);
      chk("req", dm_req, 1);
      chk("we", dm_we, !v.ld);
      chk("addr", dm_addr, {v.addr[31:2], 2'b00});
      chk("be", dm_be, v.be);
      if (!v.ld) chk("wdata", dm_wdata, v.wd);
      chk("stall_acc", stall, 1);
      chk("berr_acc", bus_err, 0);
      @(posedge clk); #1;
      if (c == v.dly) break;
    end
    dm_ack = 0;
    @(negedge clk);
    chk("resp_req", dm_req, 0);
    chk("resp_stall", stall, 0);
    if (v.dly >= TO) begin
      chk("bus_err", bus_err, 1);
      chk("to_wbv", wb_valid, 0);
    end else begin
      chk("wb_valid", wb_valid, v.ld);
      if (v.ld) prev_rd = v.res;
      chk("wb_rdata", wb_rdata, prev_rd);
    end
  endtask
  initial begin
    vec_t tbl[14];
    vec_t rv;
    tbl[0]  = '{1, 0, 3'd0, 2'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 4'hF, 32'h0, 32'hDEADBEEF};
    tbl[1]  = '{1, 0, 3'd1, 2'd2, 32'h103, 32'h0, 32'h80112233, 0, 1, 4'h8, 32'h0, 32'hFFFFFF80};
    tbl[2]  = '{1, 0, 3'd3, 2'd2, 32'h103, 32'h0, 32'h80112233, 1, 1, 4'h8, 32'h0, 32'h00000080};
    tbl[3]  = '{1, 0, 3'd4, 2'd2, 32'h102, 32'h0, 32'h80112233, 0, 1, 4'hC, 32'h0, 32'h00008011};
    tbl[4]  = '{0, 1, 3'd0, 2'd1, 32'h102, 32'h0000ABCD, 32'h0, 3, 1, 4'hC, 32'hABCDABCD, 32'h0};
    tbl[5]  = '{1, 0, 3'd0, 2'd2, 32'h101, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0};
    tbl[6]  = '{1, 0, 3'd2, 2'd2, 32'h100, 32'h0, 32'h80112233, 2, 1, 4'h3, 32'h0, 32'h00002233};
    tbl[7]  = '{0, 1, 3'd0, 2'd0, 32'h101, 32'h0000005A, 32'h0, 1, 1, 4'h2, 32'h5A5A5A5A, 32'h0};
    tbl[8]  = '{0, 1, 3'd0, 2'd2, 32'h104, 32'h12345678, 32'h0, 0, 1, 4'hF, 32'h12345678, 32'h0};
    tbl[9]  = '{1, 0, 3'd5, 2'd2, 32'h108, 32'h0, 32'hCAFEF00D, 0, 1, 4'hF, 32'h0, 32'hCAFEF00D};
    tbl[10] = '{1, 1, 3'd3, 2'd2, 32'h101, 32'h0, 32'h0000A500, 0, 1, 4'h2, 32'h0, 32'h000000A5};
    tbl[11] = '{0, 1, 3'd0, 2'd1, 32'h101, 32'h0000FFFF, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0};
    tbl[12] = '{1, 0, 3'd0, 2'd2, 32'h10C, 32'h0, 32'h0, 99, 1, 4'hF, 32'h0, 32'h0};
    tbl[13] = '{1, 0, 3'd2, 2'd2, 32'h102, 32'h0, 32'h7FFF0000, 0, 1, 4'hC, 32'h0, 32'h00007FFF};
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req", dm_req, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_stall", stall, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_be", dm_be, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_wb_rdata", wb_rdata, 0);
    chk("rst_flags", {wb_valid, misalign, bus_err}, 0);
    rst = 0;
    for (int i = 0; i < 14; i++) op(tbl[i]);
    @(posedge clk); #1;
    mem_valid = 1; mem_is_load = 1; mem_is_store = 0; mem_ld_type = 0; mem_addr = 32'h200; dm_ack = 0;
    @(posedge clk); #1;
    mem_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("midrst_req_before", dm_req, 1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_req", dm_req, 0);
    chk("midrst_wbv", wb_valid, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_addr", dm_addr, 0);
    chk("midrst_be", dm_be, 0);
    prev_rd = 0;
    op(model(1, 0, 3'd0, 2'd2, 32'h200, 32'h0, 32'h13579BDF, 1));
    for (int i = 0; i < 200; i++) begin
      logic ld, st;
      logic [31:0] a;
      int k;
      ld = 1'($urandom);
      st = ld ? 1'($urandom) : 1'b1;
      a = $urandom;
      k = $urandom % 4;
      if (k != 0) a[0] = 1'b0;
      if (k == 1) a[1] = 1'b0;
      rv = model(ld, st, 3'($urandom % 8), 2'($urandom % 3), a, $urandom, $urandom,
                 ($urandom % 16 == 0) ? 99 : int'($urandom % 4));
      op(rv);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
